// File: rtl/mod_sub_pipe_pkg.sv
// Shared definitions for the segmented modular subtractor.
//   DataSizeDefault / SegSizeDefault : default operand and borrow-segment widths
//   NsegDefault                      : number of segment stages at the defaults
//   upper_offset / lower_offset      : bit offsets of each stage's slot in the
//                                      packed triangular side-band stores
package mod_sub_pipe_pkg;

    localparam int unsigned DataSizeDefault = 64;
    localparam int unsigned SegSizeDefault  = 16;
    localparam int unsigned NsegDefault     = DataSizeDefault / SegSizeDefault;

    // Stage k keeps the (nseg-1-k) segments of an operand it has not consumed yet.
    function automatic int unsigned upper_offset(input int unsigned k,
                                                 input int unsigned nseg,
                                                 input int unsigned seg);
        int unsigned off;
        off = 0;
        for (int unsigned j = 0; j < k; j++) begin
            off += (nseg - 1 - j) * seg;
        end
        return off;
    endfunction

    // Stage k holds the (k+1) difference segments produced so far.
    function automatic int unsigned lower_offset(input int unsigned k,
                                                 input int unsigned seg);
        int unsigned off;
        off = 0;
        for (int unsigned j = 0; j < k; j++) begin
            off += (j + 1) * seg;
        end
        return off;
    endfunction

endpackage

// File: rtl/mod_sub_pipe_fs.sv
// One-bit full subtractor (FS): {bo, d} = x - y - bi.
//   x, y : minuend / subtrahend bits
//   bi   : borrow in
//   bo   : borrow out
//   d    : difference bit
module mod_sub_pipe_fs (
    input  logic x,
    input  logic y,
    input  logic bi,
    output logic bo,
    output logic d
);

    assign d  = x ^ y ^ bi;
    assign bo = (~x & y) | (~(x ^ y) & bi);

endmodule

// File: rtl/mod_sub_pipe.sv
// Pipelined modular subtractor: r = (a - b) mod q for a, b < q.
// NSEG ripple-borrow segment stages (LSB first) followed by one correction stage
// that adds q back when the full subtraction borrowed. Latency NSEG+1, one op per
// cycle, global stall when the output is held. Requires NSEG >= 2.
//   clk, reset          : clock, synchronous active-low reset
//   in_valid / in_ready : operand handshake (a, b, q)
//   out_valid/out_ready : result handshake (r)
module mod_sub_pipe
    import mod_sub_pipe_pkg::*;
#(
    parameter int unsigned DATA_SIZE = DataSizeDefault,
    parameter int unsigned SEG_SIZE  = SegSizeDefault
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 in_valid,
    output logic                 in_ready,
    input  logic [DATA_SIZE-1:0] a,
    input  logic [DATA_SIZE-1:0] b,
    input  logic [DATA_SIZE-1:0] q,
    output logic                 out_valid,
    input  logic                 out_ready,
    output logic [DATA_SIZE-1:0] r
);

    localparam int unsigned NSEG   = DATA_SIZE / SEG_SIZE;
    localparam int unsigned UpperW = upper_offset(NSEG - 1, NSEG, SEG_SIZE);
    localparam int unsigned LowerW = lower_offset(NSEG, SEG_SIZE);
    localparam int unsigned LastLo = lower_offset(NSEG - 1, SEG_SIZE);

    logic                 advance;
    logic [UpperW-1:0]    a_up_q, a_up_d;
    logic [UpperW-1:0]    b_up_q, b_up_d;
    logic [LowerW-1:0]    diff_q, diff_d;
    logic [DATA_SIZE-1:0] mod_q [NSEG];
    logic [DATA_SIZE-1:0] mod_d [NSEG];
    logic [NSEG-1:0]      borrow_q, borrow_d;
    logic [NSEG-1:0]      valid_q, valid_d;
    logic                 out_valid_q;
    logic [DATA_SIZE-1:0] r_q, r_d;
    logic [DATA_SIZE-1:0] diff_full;

    // Whole pipeline moves together unless the output is being held.
    assign advance  = !(out_valid_q && !out_ready);
    assign in_ready = advance;

    for (genvar k = 0; k < NSEG; k++) begin : gen_stage
        logic [SEG_SIZE-1:0] seg_a, seg_b, seg_d;
        logic [SEG_SIZE:0]   chain;

        if (k == 0) begin : gen_head
            localparam int unsigned CarryW = (NSEG - 1) * SEG_SIZE;
            assign seg_a                 = a[SEG_SIZE-1:0];
            assign seg_b                 = b[SEG_SIZE-1:0];
            assign chain[0]              = 1'b0;
            assign valid_d[0]            = in_valid;
            assign mod_d[0]              = q;
            assign diff_d[SEG_SIZE-1:0]  = seg_d;
            assign a_up_d[CarryW-1:0]    = a[DATA_SIZE-1:SEG_SIZE];
            assign b_up_d[CarryW-1:0]    = b[DATA_SIZE-1:SEG_SIZE];
        end else begin : gen_tail
            localparam int unsigned PrevUp = upper_offset(k - 1, NSEG, SEG_SIZE);
            localparam int unsigned PrevLo = lower_offset(k - 1, SEG_SIZE);
            localparam int unsigned ThisLo = lower_offset(k, SEG_SIZE);
            // Lowest segment of the previous slot is the one this stage consumes.
            assign seg_a      = a_up_q[PrevUp +: SEG_SIZE];
            assign seg_b      = b_up_q[PrevUp +: SEG_SIZE];
            assign chain[0]   = borrow_q[k-1];
            assign valid_d[k] = valid_q[k-1];
            assign mod_d[k]   = mod_q[k-1];
            assign diff_d[ThisLo +: (k + 1) * SEG_SIZE] =
                {seg_d, diff_q[PrevLo +: k * SEG_SIZE]};

            if (k < NSEG - 1) begin : gen_carry
                localparam int unsigned ThisUp = upper_offset(k, NSEG, SEG_SIZE);
                localparam int unsigned CarryW = (NSEG - 1 - k) * SEG_SIZE;
                assign a_up_d[ThisUp +: CarryW] = a_up_q[PrevUp + SEG_SIZE +: CarryW];
                assign b_up_d[ThisUp +: CarryW] = b_up_q[PrevUp + SEG_SIZE +: CarryW];
            end
        end

        for (genvar i = 0; i < SEG_SIZE; i++) begin : gen_bit
            mod_sub_pipe_fs u_fs (
                .x  (seg_a[i]),
                .y  (seg_b[i]),
                .bi (chain[i]),
                .bo (chain[i+1]),
                .d  (seg_d[i])
            );
        end

        assign borrow_d[k] = chain[SEG_SIZE];
    end

    // A final borrow means a < b, so q is added back (wraps in DATA_SIZE bits).
    assign diff_full = diff_q[LastLo +: DATA_SIZE];
    assign r_d       = borrow_q[NSEG-1] ? diff_full + mod_q[NSEG-1] : diff_full;

    always_ff @(posedge clk) begin
        if (!reset) begin
            valid_q     <= '0;
            borrow_q    <= '0;
            a_up_q      <= '0;
            b_up_q      <= '0;
            diff_q      <= '0;
            mod_q       <= '{default: '0};
            out_valid_q <= 1'b0;
            r_q         <= '0;
        end else if (advance) begin
            valid_q     <= valid_d;
            borrow_q    <= borrow_d;
            a_up_q      <= a_up_d;
            b_up_q      <= b_up_d;
            diff_q      <= diff_d;
            mod_q       <= mod_d;
            out_valid_q <= valid_q[NSEG-1];
            // Bubbles leave the last result on r.
            if (valid_q[NSEG-1]) begin
                r_q <= r_d;
            end
        end
    end

    assign out_valid = out_valid_q;
    assign r         = r_q;

endmodule

// File: tb/tb_mod_sub_pipe.sv
module tb_mod_sub_pipe;

    localparam int unsigned W = 64;

    logic         clk = 1'b0;
    logic         reset;
    logic         in_valid;
    logic         in_ready;
    logic         out_valid;
    logic         out_ready;
    logic [W-1:0] a, b, q, r;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    mod_sub_pipe #(
        .DATA_SIZE (64),
        .SEG_SIZE  (16)
    ) dut (
        .clk       (clk),
        .reset     (reset),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .a         (a),
        .b         (b),
        .q         (q),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .r         (r)
    );

    // Reference: (x - y) mod m using one extra bit of headroom.
    function automatic logic [W-1:0] ref_mod_sub(input logic [W-1:0] x, input logic [W-1:0] y,
                                                 input logic [W-1:0] m);
        logic [W:0] t;
        if (x >= y) return x - y;
        t = {1'b0, x} + {1'b0, m} - {1'b0, y};
        return t[W-1:0];
    endfunction

    function automatic logic [W-1:0] rand64();
        return {$urandom(), $urandom()};
    endfunction

    function automatic logic [W-1:0] rand_mod();
        logic [W-1:0] m;
        m = rand64();
        if (m < 2) m = 2;
        return m;
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Issue one op into an idle pipe and wait (bounded) for its result.
    task automatic do_op(input logic [W-1:0] ia, input logic [W-1:0] ib, input logic [W-1:0] iq,
                         output logic [W-1:0] ro, output int lat);
        int cnt;
        out_ready = 1'b1;
        in_valid  = 1'b1;
        a = ia; b = ib; q = iq;
        tick();
        in_valid = 1'b0;
        cnt = 1;
        while (out_valid !== 1'b1 && cnt < 20) begin
            tick();
            cnt++;
        end
        lat = (out_valid === 1'b1) ? cnt : -1;
        ro  = r;
        tick();
    endtask

    task automatic test_reset();
        int seen;
        reset = 1'b0; out_ready = 1'b1;
        in_valid = 1'b1; a = 64'd5; b = 64'd3; q = 64'd7;
        repeat (3) tick();
        checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL reset_out_valid got=%b want=0", out_valid); end
        checks++; if (r !== 64'd0) begin errors++; $display("FAIL reset_r got=%h want=0", r); end
        checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL reset_in_ready got=%b want=1", in_ready); end
        in_valid = 1'b0;
        reset = 1'b1;
        seen = 0;
        repeat (8) begin
            tick();
            if (out_valid === 1'b1) seen++;
        end
        checks++; if (seen != 0) begin errors++; $display("FAIL reset_ignored_input got=%0d outputs want=0", seen); end
    endtask

    task automatic test_basic();
        logic [W-1:0] res; int lat;
        do_op(64'd5, 64'd3, 64'd7, res, lat);
        checks++; if (res !== 64'd2) begin errors++; $display("FAIL basic_r got=%h want=2", res); end
        checks++; if (lat != 5) begin errors++; $display("FAIL basic_latency got=%0d want=5", lat); end
    endtask

    task automatic test_wrap();
        logic [W-1:0] ta [2] = '{64'd3, 64'd0};
        logic [W-1:0] tb [2] = '{64'd5, 64'd12288};
        logic [W-1:0] tq [2] = '{64'd7, 64'd12289};
        logic [W-1:0] te [2] = '{64'd5, 64'd1};
        logic [W-1:0] res; int lat;
        for (int i = 0; i < 2; i++) begin
            do_op(ta[i], tb[i], tq[i], res, lat);
            checks++; if (res !== te[i]) begin errors++; $display("FAIL wrap_r[%0d] got=%h want=%h", i, res, te[i]); end
            checks++; if (lat != 5) begin errors++; $display("FAIL wrap_latency[%0d] got=%0d want=5", i, lat); end
        end
    endtask

    task automatic test_cross_borrow();
        logic [W-1:0] ta [2] = '{64'h0000_0000_0001_0000, 64'h0001_0000_0000_0000};
        logic [W-1:0] te [2] = '{64'h0000_0000_0000_FFFF, 64'h0000_FFFF_FFFF_FFFF};
        logic [W-1:0] res; int lat;
        for (int i = 0; i < 2; i++) begin
            do_op(ta[i], 64'd1, 64'h8000_0000_0000_0000, res, lat);
            checks++; if (res !== te[i]) begin errors++; $display("FAIL cross_r[%0d] got=%h want=%h", i, res, te[i]); end
            checks++; if (lat != 5) begin errors++; $display("FAIL cross_latency[%0d] got=%0d want=5", i, lat); end
        end
    endtask

    task automatic test_back_to_back();
        logic [W-1:0] oa [8], ob [8], oq [8];
        logic [W-1:0] exp_q [$];
        logic [W-1:0] held_r;
        int sent = 0, got = 0, oc = 0;
        for (int i = 0; i < 8; i++) begin
            oq[i] = rand_mod();
            oa[i] = rand64() % oq[i];
            ob[i] = rand64() % oq[i];
        end
        held_r = '0;
        for (int cyc = 0; cyc < 60 && got < 8; cyc++) begin
            if (out_valid === 1'b1) oc++;
            out_ready = !(out_valid === 1'b1 && oc >= 3 && oc <= 5);
            in_valid = (sent < 8);
            if (sent < 8) begin a = oa[sent]; b = ob[sent]; q = oq[sent]; end
            #1;
            if (!out_ready) begin
                checks++; if (in_ready !== 1'b0) begin errors++; $display("FAIL b2b_stall_in_ready got=%b want=0", in_ready); end
                if (oc == 3) held_r = r;
                else begin
                    checks++; if (r !== held_r) begin errors++; $display("FAIL b2b_stall_r got=%h want=%h", r, held_r); end
                end
            end else begin
                checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL b2b_in_ready got=%b want=1", in_ready); end
            end
            if (in_valid && in_ready === 1'b1) begin
                exp_q.push_back(ref_mod_sub(oa[sent], ob[sent], oq[sent]));
                sent++;
            end
            if (out_valid === 1'b1 && out_ready) begin
                checks++;
                if (exp_q.size() == 0) begin
                    errors++; $display("FAIL b2b_extra_output got=%h want=none", r);
                end else if (r !== exp_q[0]) begin
                    errors++; $display("FAIL b2b_r[%0d] got=%h want=%h", got, r, exp_q[0]);
                    void'(exp_q.pop_front());
                end else begin
                    void'(exp_q.pop_front());
                end
                got++;
            end
            tick();
        end
        in_valid = 1'b0; out_ready = 1'b1;
        checks++; if (got != 8) begin errors++; $display("FAIL b2b_count got=%0d want=8", got); end
    endtask

    task automatic test_reset_mid();
        logic [W-1:0] res; int lat; int seen;
        out_ready = 1'b1;
        for (int i = 0; i < 3; i++) begin
            q = rand_mod(); a = rand64() % q; b = rand64() % q;
            in_valid = 1'b1;
            tick();
        end
        in_valid = 1'b0;
        tick();
        checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL rmid_early_out got=%b want=0", out_valid); end
        reset = 1'b0;
        #1;
        checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL rmid_in_ready got=%b want=1", in_ready); end
        tick();
        checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL rmid_out_valid got=%b want=0", out_valid); end
        checks++; if (r !== 64'd0) begin errors++; $display("FAIL rmid_r got=%h want=0", r); end
        reset = 1'b1;
        seen = 0;
        repeat (10) begin
            tick();
            if (out_valid === 1'b1) seen++;
        end
        checks++; if (seen != 0) begin errors++; $display("FAIL rmid_stale got=%0d outputs want=0", seen); end
        do_op(64'd9, 64'd4, 64'd11, res, lat);
        checks++; if (res !== 64'd5) begin errors++; $display("FAIL rmid_next_r got=%h want=5", res); end
        checks++; if (lat != 5) begin errors++; $display("FAIL rmid_next_latency got=%0d want=5", lat); end
    endtask

    task automatic test_zero_bubble();
        logic [W-1:0] qs [4];
        int outs = 0;
        qs[0] = 64'd7; qs[1] = 64'd12289; qs[2] = 64'hFFFF_FFFF_FFFF_FFFF; qs[3] = rand_mod();
        out_ready = 1'b1;
        for (int cyc = 0; cyc < 30; cyc++) begin
            in_valid = (cyc < 16) && (cyc % 2 == 0);
            if (in_valid) begin
                q = qs[cyc / 4];
                a = ((cyc % 4) == 0) ? qs[cyc / 4] - 1 : 64'd0;
                b = a;
            end
            if (out_valid === 1'b1) begin
                outs++;
                checks++; if (r !== 64'd0) begin errors++; $display("FAIL zero_r[%0d] got=%h want=0", outs, r); end
            end
            tick();
        end
        in_valid = 1'b0;
        checks++; if (outs != 8) begin errors++; $display("FAIL zero_out_count got=%0d want=8", outs); end
    endtask

    task automatic test_random();
        logic [W-1:0] exp_q [$];
        logic [W-1:0] prev_r;
        logic         prev_stall = 1'b0;
        int sent = 0, got = 0;
        in_valid = 1'b0;
        prev_r = '0;
        for (int cyc = 0; cyc < 600 && got < 40; cyc++) begin
            if (prev_stall) begin
                checks++;
                if (out_valid !== 1'b1 || r !== prev_r) begin
                    errors++; $display("FAIL rand_stall_hold got=%b/%h want=1/%h", out_valid, r, prev_r);
                end
            end
            out_ready = ($urandom_range(0, 3) != 0);
            if (!in_valid && sent < 40 && $urandom_range(0, 2) != 0) begin
                q = rand_mod(); a = rand64() % q; b = rand64() % q;
                if ($urandom_range(0, 3) == 0) b = a;
                in_valid = 1'b1;
            end
            #1;
            if (in_valid && in_ready === 1'b1) begin
                exp_q.push_back(ref_mod_sub(a, b, q));
                sent++;
            end
            if (out_valid === 1'b1 && out_ready) begin
                checks++;
                if (exp_q.size() == 0) begin
                    errors++; $display("FAIL rand_extra_output got=%h want=none", r);
                end else begin
                    if (r !== exp_q[0]) begin
                        errors++; $display("FAIL rand_r[%0d] got=%h want=%h", got, r, exp_q[0]);
                    end
                    void'(exp_q.pop_front());
                end
                got++;
            end
            prev_stall = (out_valid === 1'b1) && !out_ready;
            prev_r = r;
            if (in_valid && in_ready === 1'b1) begin
                tick();
                in_valid = 1'b0;
            end else begin
                tick();
            end
        end
        in_valid = 1'b0; out_ready = 1'b1;
        checks++; if (got != 40) begin errors++; $display("FAIL rand_count got=%0d want=40", got); end
    endtask

    initial begin
        reset = 1'b0; in_valid = 1'b0; out_ready = 1'b1;
        a = '0; b = '0; q = '0;
        test_reset();
        test_basic();
        test_wrap();
        test_cross_borrow();
        test_back_to_back();
        test_reset_mid();
        test_zero_bubble();
        test_random();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/mod_sub_pipe.md
MOD_SUB_PIPE -- requirements
Module: mod_sub_pipe

Interface
REQ-001 SHALL have parameter DATA_SIZE, default 64, operand/modulus width in bits.
REQ-002 SHALL have parameter SEG_SIZE, default 16, borrow-segment width; DATA_SIZE SHALL be an integer multiple of SEG_SIZE.
REQ-003 SHALL have port clk  input  1  single clock; all state changes on rising edge.
REQ-004 SHALL have port reset  input  1  synchronous, active-low reset (one clock; reset is synchronous and active-low).
REQ-005 SHALL have port in_valid  input  1  operand triple present.
REQ-006 SHALL have port in_ready  output  1  operand accepted when in_valid && in_ready.
REQ-007 SHALL have port a  input  DATA_SIZE  minuend, a < q.
REQ-008 SHALL have port b  input  DATA_SIZE  subtrahend, b < q.
REQ-009 SHALL have port q  input  DATA_SIZE  modulus, sampled per operation.
REQ-010 SHALL have port out_valid  output  1  result present.
REQ-011 SHALL have port out_ready  input  1  downstream accepts when out_valid && out_ready.
REQ-012 SHALL have port r  output  DATA_SIZE  (a - b) mod q.

Function
REQ-013 SHALL compute r = a - b if a >= b, else a - b + q, exact in DATA_SIZE bits; behaviour for a >= q or b >= q is unspecified.
REQ-014 SHALL split subtraction into NSEG = DATA_SIZE/SEG_SIZE pipeline stages, stage k subtracting segment k (LSB first) with the borrow registered from stage k-1; stage 0 borrow-in = 0.
REQ-015 SHALL carry unprocessed upper segments of a, b, completed lower difference segments, q and a valid bit alongside each stage.
REQ-016 SHALL apply correction in one final stage: add q (mod 2^DATA_SIZE) when final borrow = 1, else pass the difference.
REQ-017 SHALL have latency NSEG+1 cycles from accept to out_valid with no stalls (5 at defaults) and accept one operation per cycle.
REQ-018 SHALL stall globally: when out_valid && !out_ready, every stage register, including valids, SHALL hold.
REQ-019 SHALL drive in_ready = !(out_valid && !out_ready), combinationally.
REQ-020 SHALL keep r and out_valid stable while stalled; r SHALL change only on an advancing edge.
REQ-021 SHALL propagate bubbles: stage with valid 0 SHALL advance freely and SHALL NOT produce out_valid.
REQ-022 SHALL allow accept and output handshake in the same cycle with no bubble inserted.
REQ-023 SHALL preserve operation order; no reordering, dropping or duplication.

Reset
REQ-024 SHALL, on reset = 0 at a rising edge, clear all stage valid bits, out_valid = 0, r = 0; data registers may clear to 0.
REQ-025 SHALL discard all in-flight operations on reset mid-operation; first output after reset release SHALL come from an operation accepted after release.
REQ-026 SHALL hold in_ready = 1 during reset (out_valid = 0), while ignoring in_valid until reset = 1.

Structure
REQ-027 SHALL place DATA_SIZE and SEG_SIZE defaults and derived NSEG in the shared defines file.
REQ-028 SHALL instantiate a one-bit full-subtractor sub-module FS (inputs x, y, bi; outputs bo, d; {bo,d} = x - y - bi) in a SEG_SIZE-long ripple chain per segment stage.
REQ-029 SHALL implement the correction adder with a plain vector add, not FS.

Verification
REQ-030 SHALL cover basic: DATA_SIZE=64, q=7, a=5, b=3 -> r=2 exactly 5 cycles after accept.
REQ-031 SHALL cover wrap: q=7, a=3, b=5 -> r=5; q=12289, a=0, b=12288 -> r=1.
REQ-032 SHALL cover cross-segment borrow: q=2^63, a=0x0000_0000_0001_0000, b=1 -> r=0x0000_0000_0000_FFFF; a=2^48, b=1 -> r=0x0000_FFFF_FFFF_FFFF.
REQ-033 SHALL cover back-to-back with backpressure: 8 random ops on consecutive cycles, out_ready low cycles 3-5 of output -> 8 correct results in order, r stable while stalled, in_ready low during stall.
REQ-034 SHALL cover reset mid-operation: accept 3 ops, assert reset for 1 cycle after 2 cycles -> out_valid=0, r=0 next cycle; no stale result appears; next op (a=9,b=4,q=11) -> r=5 after 5 cycles.
REQ-035 SHALL cover equality/zero: a=b=q-1 -> r=0; a=b=0 -> r=0, with a bubble between each op producing no extra out_valid.
